// File: rtl/shifter_pkg.sv
// shifter_pkg: shared state encoding and default width for the load/rotate shifter control slice.
package shifter_pkg;
    localparam int SHIFTER_N = 8;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/shift_counter.sv
// shift_counter: counts shift cycles; tc flags the last shift of a word (count == SHIFTS-1).
module shift_counter #(
    parameter int SHIFTS = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CNT_W = $clog2(SHIFTS + 1);
    logic [CNT_W-1:0] count;
    always_ff @(posedge clock or negedge reset)
        if (!reset) count <= '0;
        else if (clr) count <= '0;
        else if (en) count <= count + 1'b1;
    assign tc = count == CNT_W'(SHIFTS - 1);
endmodule

// File: rtl/shift_load_ctrl.sv
// shift_load_ctrl: accepts words over valid/ready, then drives one load cycle and SHIFTS shift cycles.
// Optional ROT_CHECK_EN adds shf_outp/rot_err to flag a full rotation that fails to restore the word.
module shift_load_ctrl
    import shifter_pkg::*;
#(
    parameter int N      = SHIFTER_N,
    parameter int SHIFTS = N
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [N-1:0] in_data,
    output logic         in_ready,
    input  logic         stall,
    output logic [N-1:0] par_out,
    output logic         load,
    output logic         shift_ena,
    output logic         busy,
    output logic         done
`ifdef ROT_CHECK_EN
    ,
    input  logic [N-1:0] shf_outp,
    output logic         rot_err
`endif
);
    state_t state, state_nx;
    logic   accept, tc;
    assign accept = in_valid && in_ready;
    always_ff @(posedge clock or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_nx;
    always_ff @(posedge clock or negedge reset)
        if (!reset) par_out <= '0;
        else if (accept) par_out <= in_data;
    // Only shift_ena looks at an input (stall); everything else is pure state decode.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        load      = 1'b0;
        shift_ena = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                state_nx = in_valid ? LOAD : IDLE;
            end
            LOAD: begin
                load      = 1'b1;
                shift_ena = 1'b1;
                busy      = 1'b1;
                state_nx  = SHIFT;
            end
            SHIFT: begin
                shift_ena = !stall;
                busy      = 1'b1;
                state_nx  = (tc && !stall) ? DONE : SHIFT;
            end
            DONE: begin
                done     = 1'b1;
                in_ready = 1'b1;
                state_nx = in_valid ? LOAD : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
    // Counter parks on SHIFTS-1 at the last shift so it never wraps.
    shift_counter #(.SHIFTS(SHIFTS)) u_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (state == LOAD),
        .en    (state == SHIFT && !stall && !tc),
        .tc    (tc)
    );
`ifdef ROT_CHECK_EN
    always_ff @(posedge clock or negedge reset)
        if (!reset) rot_err <= 1'b0;
        else if (state == DONE) rot_err <= (SHIFTS == N) && (shf_outp != par_out);
        else if (accept) rot_err <= 1'b0;
`endif
endmodule

// File: tb/tb_shift_load_ctrl.sv
// tb_shift_load_ctrl: scoreboarded random and directed test of the shift/load controller.
module tb_shift_load_ctrl;
    import shifter_pkg::*;
    localparam int N      = SHIFTER_N;
    localparam int SHIFTS = N;

    logic         clock = 1'b0;
    logic         reset, in_valid, stall;
    logic [N-1:0] in_data, par_out;
    logic         in_ready, load, shift_ena, busy, done;
`ifdef ROT_CHECK_EN
    logic [N-1:0] shf_outp, rot;
    logic         rot_err;
    bit           force_bad, chk_rot;
`endif

    always #5 clock = ~clock;

    shift_load_ctrl #(.N(N), .SHIFTS(SHIFTS)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .stall     (stall),
        .par_out   (par_out),
        .load      (load),
        .shift_ena (shift_ena),
        .busy      (busy),
        .done      (done)
`ifdef ROT_CHECK_EN
        ,
        .shf_outp  (shf_outp),
        .rot_err   (rot_err)
`endif
    );

    typedef struct {
        logic [N-1:0] word;
        int           ld;
    } txn_t;
    txn_t sb[$];
    txn_t t_acc, t_mon;

    int           total, bad, cyc, acc_cnt, nsh, nld, ld_cyc, last_done, prev_done, t_ld;
    logic [N-1:0] cur_word = '0;
    bit           stall_h [0:8191];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    // Done lands one cycle after the SHIFTS-th unstalled cycle following the load cycle.
    function automatic int exp_done(input int ld);
        int c = ld;
        int k = 0;
        while (k < SHIFTS && c < cyc) begin
            c++;
            if (!stall_h[c]) k++;
        end
        return c + 1;
    endfunction

    always @(posedge clock) begin
        cyc++;
        if (reset && in_valid && in_ready) begin
            t_acc.word = in_data;
            t_acc.ld   = cyc;
            sb.push_back(t_acc);
            cur_word = in_data;
            acc_cnt++;
        end
    end

`ifdef ROT_CHECK_EN
    always @(posedge clock or negedge reset)
        if (!reset) rot <= '0;
        else if (load && shift_ena) rot <= par_out;
        else if (shift_ena) rot <= {rot[N-2:0], rot[N-1]};
    assign shf_outp = force_bad ? '0 : rot;
`endif

    always @(negedge clock) if (reset) begin
        stall_h[cyc] = stall;
`ifdef ROT_CHECK_EN
        if (chk_rot) begin
            check("rot_err_after_done", rot_err, force_bad);
            chk_rot = 0;
        end
`endif
        if (load) begin
            nld++;
            ld_cyc = cyc;
        end
        if (shift_ena) nsh++;
        check("par_out", par_out, cur_word);
        if (done) begin
            check("done_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                t_mon = sb.pop_front();
                check("done_cycle", cyc, exp_done(t_mon.ld));
                check("done_word", par_out, t_mon.word);
                check("load_cycle", ld_cyc, t_mon.ld);
                check("load_count", nld, 1);
                check("shift_count", nsh, SHIFTS + 1);
            end
            check("done_outs", {busy, in_ready, load, shift_ena}, 4'b0100);
            nsh = 0;
            nld = 0;
            prev_done = last_done;
            last_done = cyc;
`ifdef ROT_CHECK_EN
            chk_rot = 1;
`endif
        end else if (sb.size() == 0)
            check("idle_outs", {busy, in_ready, load, shift_ena}, 4'b0100);
        else
            check("busy_outs", {busy, in_ready}, 2'b10);
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_acc(input bit toggle);
        int n = acc_cnt;
        for (int i = 0; i < 60 && acc_cnt == n; i++) begin
            @(posedge clock);
            #1;
            if (toggle && acc_cnt == n) in_data = N'($urandom);
        end
        check("accept_seen", acc_cnt != n, 1);
    endtask

    task automatic send(input logic [N-1:0] w);
        in_valid = 1'b1;
        in_data  = w;
        wait_acc(0);
        in_valid = 1'b0;
        t_ld     = cyc;
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        stall    = 1'b0;
`ifdef ROT_CHECK_EN
        force_bad = 0;
`endif
        #1;
        check("rst_outs", {load, shift_ena, busy, done, in_ready}, 5'b00001);
        check("rst_par", par_out, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;

        send(8'hA5);
        idle(14);
        check("latency", last_done - t_ld, SHIFTS + 1);

        in_valid = 1'b1;
        in_data  = 8'h3C;
        wait_acc(0);
        in_data = 8'hF0;
        wait_acc(1);
        in_valid = 1'b0;
        idle(14);
        check("b2b_gap", last_done - prev_done, SHIFTS + 2);

        send(8'h5A);
        idle(3);
        stall = 1'b1;
        idle(3);
        stall = 1'b0;
        idle(14);
        check("stall_delay", last_done - t_ld, SHIFTS + 4);

        send(8'hC3);
        idle(4);
        #2 reset = 1'b0;
        #1;
        check("midrst_outs", {load, shift_ena, busy, done, in_ready}, 5'b00001);
        check("midrst_par", par_out, 0);
        sb.delete();
        cur_word = '0;
        nsh = 0;
        nld = 0;
`ifdef ROT_CHECK_EN
        chk_rot = 0;
`endif
        idle(2);
        reset = 1'b1;
        send(8'h96);
        idle(14);
        check("after_rst_latency", last_done - t_ld, SHIFTS + 1);

`ifdef ROT_CHECK_EN
        force_bad = 1;
        send(8'h81);
        idle(14);
        check("rot_sticky", rot_err, 1);
        force_bad = 0;
        send(8'h7E);
        check("rot_clear", rot_err, 0);
        idle(14);
`endif

        repeat (400) begin
            in_valid = 1'($urandom);
            in_data  = N'($urandom);
            stall    = ($urandom % 4) == 0;
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        stall    = 1'b0;
        for (int i = 0; i < 60 && sb.size() != 0; i++) idle(1);
        check("drain", sb.size(), 0);
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
